// File: rtl/microwave_keypad_entry_if.sv
// Keypad/display bundle of the microwave time-entry block.
// The master drives the raw keys and controls; the slave returns the BCD digits.
interface microwave_keypad_entry_if;
  logic [0:9] switches;
  logic       clearn;
  logic       lock;
  logic [3:0] min;
  logic [3:0] tensec;
  logic [3:0] sec;
  logic       digit_strobe;
  logic       time_valid;

  modport master (
    output switches, clearn, lock,
    input  min, tensec, sec, digit_strobe, time_valid
  );

  modport slave (
    input  switches, clearn, lock,
    output min, tensec, sec, digit_strobe, time_valid
  );
endinterface

// File: rtl/microwave_keypad_entry.sv
// Debounced 10-key entry that shifts BCD digits into a min:tensec:sec display.
// A key is accepted once per press; lock blocks entry and clearn zeroes the digits.
module microwave_keypad_entry #(
  parameter int DEB_CYCLES = 4
) (
  input logic                      clk,
  input logic                      resetn,
  microwave_keypad_entry_if.slave  kp
);

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    HELD
  } state_t;

  localparam logic [7:0] DEB_LAST = 8'(DEB_CYCLES - 1);

  logic [0:9] sync1;
  logic [0:9] code;
  logic [0:9] latched;
  logic [0:9] latched_next;
  state_t     state;
  state_t     state_next;
  logic [7:0] cnt;
  logic [7:0] cnt_next;
  logic       accept;
  logic       shift_en;
  logic [3:0] min_q;
  logic [3:0] tensec_q;
  logic [3:0] sec_q;
  logic       strobe_q;

  function automatic logic is_onehot(input logic [0:9] v);
    int n;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (v[i]) n++;
    end
    return (n == 1);
  endfunction

  function automatic logic [3:0] index_of(input logic [0:9] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  // Two-flop synchronizer for the asynchronous, bouncy keypad lines.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1 <= '0;
      code  <= '0;
    end else begin
      sync1 <= kp.switches;
      code  <= sync1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      cnt     <= 8'd0;
      latched <= '0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      latched <= latched_next;
    end
  end

  // HELD only returns to IDLE after DEB_CYCLES consecutive all-zero samples,
  // so any activity while a key is down (even another digit) cannot re-accept.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    latched_next = latched;
    accept       = 1'b0;
    case (state)
      IDLE: begin
        if (is_onehot(code)) begin
          latched_next = code;
          cnt_next     = 8'd1;
          state_next   = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (code == latched) begin
          if (cnt == DEB_LAST) begin
            accept     = 1'b1;
            cnt_next   = 8'd0;
            state_next = HELD;
          end else begin
            cnt_next = cnt + 8'd1;
          end
        end else begin
          cnt_next   = 8'd0;
          state_next = IDLE;
        end
      end
      HELD: begin
        if (code == '0) begin
          if (cnt == DEB_LAST) begin
            cnt_next   = 8'd0;
            state_next = IDLE;
          end else begin
            cnt_next = cnt + 8'd1;
          end
        end else begin
          cnt_next = 8'd0;
        end
      end
      default: begin
        cnt_next   = 8'd0;
        state_next = IDLE;
      end
    endcase
  end

  assign shift_en = accept && !kp.lock;

  // Clear wins over a same-edge shift, but the strobe still reports the accept.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      min_q    <= 4'd0;
      tensec_q <= 4'd0;
      sec_q    <= 4'd0;
      strobe_q <= 1'b0;
    end else begin
      strobe_q <= shift_en;
      if (!kp.clearn) begin
        min_q    <= 4'd0;
        tensec_q <= 4'd0;
        sec_q    <= 4'd0;
      end else if (shift_en) begin
        min_q    <= tensec_q;
        tensec_q <= sec_q;
        sec_q    <= index_of(latched);
      end
    end
  end

  assign kp.min          = min_q;
  assign kp.tensec       = tensec_q;
  assign kp.sec          = sec_q;
  assign kp.digit_strobe = strobe_q;
  assign kp.time_valid   = (tensec_q <= 4'd5) && ({min_q, tensec_q, sec_q} != 12'd0);

endmodule

// File: tb/tb_microwave_keypad_entry.sv
// Directed bench for microwave_keypad_entry with a digit scoreboard
// checked on every digit_strobe.
module tb_microwave_keypad_entry;

  logic clk;
  logic resetn;

  microwave_keypad_entry_if kp ();

  microwave_keypad_entry #(.DEB_CYCLES(4)) dut (
    .clk    (clk),
    .resetn (resetn),
    .kp     (kp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;
  int strobe_count = 0;
  int pushed_count = 0;

  logic [11:0] exp_q[$];
  logic [3:0]  m_min, m_ten, m_sec;
  logic        prev_strobe = 1'b0;

  function automatic logic [0:9] key_vec(input int d);
    logic [0:9] v;
    v = '0;
    v[d] = 1'b1;
    return v;
  endfunction

  function automatic logic valid_of(input logic [3:0] m, input logic [3:0] t, input logic [3:0] s);
    return (t <= 4'd5) && ({m, t, s} != 12'd0);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_stimulus(input logic [0:9] v, input int cycles);
    kp.switches = v;
    tick(cycles);
  endtask

  task automatic expect_shift(input logic [3:0] d);
    {m_min, m_ten, m_sec} = {m_ten, m_sec, d};
    exp_q.push_back({m_min, m_ten, m_sec});
    pushed_count++;
  endtask

  task automatic expect_clear_entry();
    {m_min, m_ten, m_sec} = 12'd0;
    exp_q.push_back(12'd0);
    pushed_count++;
  endtask

  task automatic check_output(input string tag, input logic [3:0] em, input logic [3:0] et,
                              input logic [3:0] es, input logic estb);
    logic [13:0] obs;
    logic [13:0] exp;
    obs = {kp.min, kp.tensec, kp.sec, kp.digit_strobe, kp.time_valid};
    exp = {em, et, es, estb, valid_of(em, et, es)};
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed {min,ten,sec,stb,vld}=%h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_count(input string tag, input int expected);
    compared++;
    assert (strobe_count === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed strobes %0d expected %0d", tag, strobe_count, expected);
    end
  endtask

  task automatic press_release(input int d);
    if (!kp.lock) expect_shift(4'(d));
    apply_stimulus(key_vec(d), 10);
    apply_stimulus('0, 10);
  endtask

  // Scoreboard: every strobe pops one expected digit triple.
  always @(negedge clk) begin
    if (resetn && kp.digit_strobe) begin
      strobe_count++;
      compared++;
      assert (!prev_strobe) else begin
        mismatched++;
        $error("[TB] FAIL strobe_width: observed strobe high 2 cycles expected 1");
      end
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $error("[TB] FAIL unexpected_strobe: observed digits %h%h%h expected no strobe",
               kp.min, kp.tensec, kp.sec);
      end else begin
        logic [11:0] e;
        e = exp_q.pop_front();
        assert ({kp.min, kp.tensec, kp.sec} === e) else begin
          mismatched++;
          $error("[TB] FAIL scoreboard: observed %h%h%h expected %h", kp.min, kp.tensec, kp.sec, e);
        end
      end
    end
    prev_strobe = resetn && kp.digit_strobe;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int base;
    m_min = 4'd0; m_ten = 4'd0; m_sec = 4'd0;
    resetn      = 1'b0;
    kp.switches = '0;
    kp.clearn   = 1'b1;
    kp.lock     = 1'b0;
    tick(2);
    check_output("reset_state", 4'd0, 4'd0, 4'd0, 1'b0);
    resetn = 1'b1;
    tick(2);

    // Clean press of 1: shift lands on the 6th rising edge.
    expect_shift(4'd1);
    kp.switches = key_vec(1);
    tick(5);
    check_output("latency_before", 4'd0, 4'd0, 4'd0, 1'b0);
    tick(1);
    check_output("latency_shift", 4'd0, 4'd0, 4'd1, 1'b1);
    tick(1);
    check_output("strobe_drop", 4'd0, 4'd0, 4'd1, 1'b0);
    apply_stimulus(key_vec(1), 3);
    apply_stimulus('0, 10);
    press_release(3);
    press_release(0);
    check_output("entry_130", 4'd1, 4'd3, 4'd0, 1'b0);
    check_count("three_strobes", 3);

    // Bouncing 7: 2-cycle toggles never reach four stable samples.
    base = strobe_count;
    expect_shift(4'd7);
    for (int i = 0; i < 5; i++) apply_stimulus((i % 2 == 0) ? key_vec(7) : 10'b0, 2);
    apply_stimulus(key_vec(7), 10);
    apply_stimulus('0, 10);
    check_count("bounce_one_strobe", base + 1);
    check_output("bounce_digits", 4'd3, 4'd0, 4'd7, 1'b0);

    // Two keys at once are ignored.
    base = strobe_count;
    apply_stimulus(key_vec(2) | key_vec(5), 20);
    apply_stimulus('0, 10);
    check_count("multi_hot_none", base);
    check_output("multi_hot_digits", 4'd3, 4'd0, 4'd7, 1'b0);

    for (int i = 0; i < 4; i++) press_release(9);
    check_output("nines", 4'd9, 4'd9, 4'd9, 1'b0);

    // Lock blocks entry; key held through unlock stays blocked until re-pressed.
    base = strobe_count;
    kp.lock = 1'b1;
    apply_stimulus(key_vec(4), 12);
    check_output("locked_digits", 4'd9, 4'd9, 4'd9, 1'b0);
    kp.lock = 1'b0;
    apply_stimulus(key_vec(4), 12);
    check_count("unlock_held_none", base);
    apply_stimulus('0, 10);
    press_release(4);
    check_output("repress_4", 4'd9, 4'd9, 4'd4, 1'b0);

    // Clear on the accept edge of 8 overrides the shift but keeps the strobe.
    expect_clear_entry();
    kp.switches = key_vec(8);
    tick(5);
    kp.clearn = 1'b0;
    tick(1);
    kp.clearn = 1'b1;
    check_output("clear_on_accept", 4'd0, 4'd0, 4'd0, 1'b1);
    apply_stimulus(key_vec(8), 6);
    apply_stimulus('0, 10);
    press_release(2);
    check_output("after_clear_2", 4'd0, 4'd0, 4'd2, 1'b0);

    // Reset mid-debounce of 6; the held key re-enters as a fresh press.
    kp.switches = key_vec(6);
    tick(3);
    resetn = 1'b0;
    #1;
    {m_min, m_ten, m_sec} = 12'd0;
    check_output("async_reset", 4'd0, 4'd0, 4'd0, 1'b0);
    tick(1);
    resetn = 1'b1;
    expect_shift(4'd6);
    tick(5);
    check_output("post_reset_wait", 4'd0, 4'd0, 4'd0, 1'b0);
    tick(1);
    check_output("post_reset_6", 4'd0, 4'd0, 4'd6, 1'b1);
    apply_stimulus(key_vec(6), 4);
    apply_stimulus('0, 10);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick(1);
    compared++;
    assert (exp_q.size() === 0) else begin
      mismatched++;
      $error("[TB] FAIL scoreboard_drain: observed %0d pending expected 0", exp_q.size());
    end
    check_count("total_strobes", pushed_count);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
